// File: rtl/aoi_edge_monitor_pkg.sv
// Shared definitions for the AOI edge monitor.
//   - Report FSM state encoding (empty / full).
//   - Default parameter values used by the top and the sync/debounce block.
//   - clog2 helper for sizing counters, never returning less than 1 bit.
package aoi_edge_monitor_pkg;

    localparam int unsigned DefSyncStages = 2;
    localparam int unsigned DefDebCycles  = 4;
    localparam int unsigned DefCntW       = 8;
    localparam int unsigned DefWinCycles  = 256;
    localparam bit          DefRstLevel   = 1'b1;

    typedef enum logic {
        RptEmpty = 1'b0,
        RptFull  = 1'b1
    } rpt_state_e;

    // Bits needed to hold values 0..value-1; at least 1 so a register can always be declared.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/aoi_sync_debounce.sv
// Synchroniser, debounce filter and edge-pulse generator for the AOI output.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   y_in         - raw AOI output, asynchronous to clk
//   level_out    - debounced, synchronised level
//   rise_pulse   - one-cycle pulse in the first cycle level_out reads 1 after being 0
//   fall_pulse   - one-cycle pulse in the first cycle level_out reads 0 after being 1
module aoi_sync_debounce
    import aoi_edge_monitor_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefSyncStages,
    parameter int unsigned DEB_CYCLES  = DefDebCycles,
    parameter bit          RST_LEVEL   = DefRstLevel
) (
    input  logic clk,
    input  logic rst_n,
    input  logic y_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int unsigned    DcW   = clog2(DEB_CYCLES);
    localparam logic [DcW-1:0] DcMax = DcW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DcW-1:0]         dc_q, dc_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    // Plain shift chain: nothing combinational between stages.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], y_in};
    assign s      = sync_q[SYNC_STAGES-1];

    always_comb begin
        dc_d    = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s != level_q) begin
            if (dc_q == DcMax) begin
                // DEB_CYCLES consecutive differing samples seen: accept the new level.
                level_d = s;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                dc_d = dc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {SYNC_STAGES{RST_LEVEL}};
            dc_q    <= '0;
            level_q <= RST_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            dc_q    <= dc_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: rtl/aoi_edge_monitor.sv
// AOI edge monitor: debounces the AOI output, counts rising/falling edges per fixed
// window and offers each window's counts over a valid/ready handshake.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   y_in                - raw AOI output, asynchronous to clk
//   clr                 - synchronous clear of window timer, counters and report
//   out_ready           - downstream accepts the pending report
//   level_out           - debounced level
//   rise_pulse/fall_pulse - one-cycle edge pulses
//   out_valid           - report pending
//   rise_cnt/fall_cnt   - edge counts of the reported window (saturating)
//   overrun             - sticky: a window report was dropped
module aoi_edge_monitor
    import aoi_edge_monitor_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefSyncStages,
    parameter int unsigned DEB_CYCLES  = DefDebCycles,
    parameter int unsigned CNT_W       = DefCntW,
    parameter int unsigned WIN_CYCLES  = DefWinCycles,
    parameter bit          RST_LEVEL   = DefRstLevel
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             y_in,
    input  logic             clr,
    input  logic             out_ready,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             out_valid,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    output logic             overrun
);

    localparam int unsigned       TimerW    = clog2(WIN_CYCLES);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CntMax    = '1;

    logic [TimerW-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]  wrk_rise_q, wrk_rise_d;
    logic [CNT_W-1:0]  wrk_fall_q, wrk_fall_d;
    logic [CNT_W-1:0]  rise_cnt_q, rise_cnt_d;
    logic [CNT_W-1:0]  fall_cnt_q, fall_cnt_d;
    logic              overrun_q, overrun_d;
    rpt_state_e        state_q, state_d;

    logic [CNT_W-1:0]  rise_inc, fall_inc;
    logic              win_end;

    aoi_sync_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES),
        .RST_LEVEL   (RST_LEVEL)
    ) u_sync_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .y_in       (y_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    assign win_end = (timer_q == TimerLast);

    // Working counts including this cycle's pulse, so a pulse on the last window
    // cycle lands in the closing snapshot.
    assign rise_inc = (wrk_rise_q == CntMax) ? wrk_rise_q : wrk_rise_q + CNT_W'(rise_pulse);
    assign fall_inc = (wrk_fall_q == CntMax) ? wrk_fall_q : wrk_fall_q + CNT_W'(fall_pulse);

    always_comb begin
        timer_d    = win_end ? '0 : timer_q + 1'b1;
        wrk_rise_d = win_end ? '0 : rise_inc;
        wrk_fall_d = win_end ? '0 : fall_inc;
        rise_cnt_d = rise_cnt_q;
        fall_cnt_d = fall_cnt_q;
        overrun_d  = overrun_q;
        state_d    = state_q;

        if (clr) begin
            // Pulses coinciding with clr are discarded along with everything else.
            timer_d    = '0;
            wrk_rise_d = '0;
            wrk_fall_d = '0;
            rise_cnt_d = '0;
            fall_cnt_d = '0;
            overrun_d  = 1'b0;
            state_d    = RptEmpty;
        end else begin
            unique case (state_q)
                RptEmpty: begin
                    if (win_end) begin
                        rise_cnt_d = rise_inc;
                        fall_cnt_d = fall_inc;
                        state_d    = RptFull;
                    end
                end
                RptFull: begin
                    if (win_end) begin
                        if (out_ready) begin
                            // Old report consumed this cycle; replace it, stay full.
                            rise_cnt_d = rise_inc;
                            fall_cnt_d = fall_inc;
                        end else begin
                            // Keep the unread report and drop the new one.
                            overrun_d = 1'b1;
                        end
                    end else if (out_ready) begin
                        state_d = RptEmpty;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q    <= '0;
            wrk_rise_q <= '0;
            wrk_fall_q <= '0;
            rise_cnt_q <= '0;
            fall_cnt_q <= '0;
            overrun_q  <= 1'b0;
            state_q    <= RptEmpty;
        end else begin
            timer_q    <= timer_d;
            wrk_rise_q <= wrk_rise_d;
            wrk_fall_q <= wrk_fall_d;
            rise_cnt_q <= rise_cnt_d;
            fall_cnt_q <= fall_cnt_d;
            overrun_q  <= overrun_d;
            state_q    <= state_d;
        end
    end

    assign out_valid = (state_q == RptFull);
    assign rise_cnt  = rise_cnt_q;
    assign fall_cnt  = fall_cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/aoi_edge_monitor.md
Name: aoi_edge_monitor

Overview:
- Downstream consumer of the 4-input AOI gate output `y`.
- Synchronises the asynchronous AOI output into the `clk` domain, debounces it, and emits one-cycle rise and fall pulses.
- Counts rising and falling edges over a fixed sampling window.
- Hands each window's counts to a downstream reader through a valid/ready handshake, with sticky overrun detection.

Parameters:
- SYNC_STAGES, 2: synchroniser flop count, minimum 2.
- DEB_CYCLES, 4: consecutive stable cycles required before the filtered level changes, minimum 1.
- CNT_W, 8: width of each edge counter; counters saturate.
- WIN_CYCLES, 256: sampling window length in clk cycles, minimum 2.
- RST_LEVEL, 1: reset value of the sync chain and filtered level. AOI output is 1 when all inputs are 0.

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: asynchronous active-low reset.
- y_in, input, 1: AOI output, asynchronous to clk.
- clr, input, 1: synchronous clear of window and counters.
- out_ready, input, 1: downstream accepts report.
- level_out, output, 1: debounced, synchronised level.
- rise_pulse, output, 1: one-cycle pulse on filtered 0->1.
- fall_pulse, output, 1: one-cycle pulse on filtered 1->0.
- out_valid, output, 1: report pending.
- rise_cnt, output, CNT_W: rising edges in the reported window.
- fall_cnt, output, CNT_W: falling edges in the reported window.
- overrun, output, 1: sticky; a window report was dropped.

Behaviour:
- Clock and reset:
  - One clock, `clk`.
  - Reset `rst_n` is asynchronous, active-low.
- Reset values:
  - Sync chain = RST_LEVEL; level_out = RST_LEVEL.
  - rise_pulse = 0, fall_pulse = 0, out_valid = 0, overrun = 0.
  - rise_cnt = 0, fall_cnt = 0.
  - Debounce counter = 0, window timer = 0, working counters = 0.
  - Reset mid-window or mid-handshake discards everything immediately.
- Synchroniser:
  - SYNC_STAGES flop chain; `s` is the last stage.
  - No logic between stages.
- Debounce:
  - Counter `dc` increments while `s != level_out` and resets to 0 when `s == level_out`.
  - When `s != level_out` and `dc == DEB_CYCLES-1`, the next edge sets `level_out = s` and `dc = 0`.
  - The filtered level updates DEB_CYCLES cycles after `s` first differs.
  - Total latency from y_in change to level_out change = SYNC_STAGES + DEB_CYCLES cycles.
  - Any excursion shorter than DEB_CYCLES cycles is rejected.
- Edge pulses:
  - rise_pulse / fall_pulse are registered and high for exactly the one cycle in which level_out holds its new value.
  - They are mutually exclusive.
- Window timer:
  - Counts 0..WIN_CYCLES-1 and wraps.
  - Working counters wrk_rise and wrk_fall increment on rise_pulse / fall_pulse and saturate at 2^CNT_W-1.
- Window end (timer == WIN_CYCLES-1):
  - An edge pulse in this same cycle is included in the closing window's snapshot.
  - Working counters load 0 on the next edge.
- Report FSM, two states:
  - EMPTY: out_valid = 0. At window end, load rise_cnt/fall_cnt from the snapshot and go to FULL.
  - FULL: out_valid = 1; rise_cnt/fall_cnt are held stable. On `out_ready`, go to EMPTY.
  - If a window end coincides with `out_ready` in FULL: load the new snapshot and stay FULL; no overrun.
  - If a window end occurs in FULL without `out_ready`: keep the old report and set overrun = 1. overrun is cleared only by reset or clr.
- clr (synchronous, has priority over all other updates except reset):
  - Zeroes timer, working counters, out_valid, rise_cnt, fall_cnt and overrun. FSM goes to EMPTY.
  - Does not touch the sync chain, debounce or level_out.
  - A pulse coinciding with clr is not counted.
- Width rules: timer width = clog2(WIN_CYCLES). Counters are unsigned.

Decomposition:
- Shared package:
  - Report FSM state encoding (EMPTY = 0, FULL = 1).
  - Default parameter constants.
  - A clog2 function.
- Sub-module: aoi_sync_debounce, covering the sync chain, debounce, level_out and the edge pulses.
- The top block holds the window timer, counters and report FSM.

Test Plan:
1. Basic fall edge: reset, then hold y_in = 1, then drive y_in 1->0 at cycle 0 and hold. With defaults, level_out falls at cycle 6. fall_pulse is high at cycle 6 only; rise_pulse stays 0.
2. Glitch rejection: drive y_in low for 3 cycles (shorter than DEB_CYCLES = 4), then back high. level_out stays 1 and no pulses occur.
3. Window report: produce 5 clean low/high pairs (5 falls, 5 rises) in window 0, with out_ready = 1. out_valid is asserted the cycle after timer == 255, with rise_cnt = 5 and fall_cnt = 5, for one cycle.
4. Saturation and boundary: set CNT_W = 3 and produce 10 rises in one window; rise_cnt = 7. Separately, land a rise_pulse exactly at timer == 255; it is counted in that window, and the next window starts at 0.
5. Overrun: hold out_ready = 0 across two window ends. The first report is held unchanged, overrun = 1 after the second window end, and the report stays unchanged after out_ready is asserted. A later clr returns overrun = 0 and out_valid = 0.
6. Async reset: assert rst_n low mid-window with out_valid = 1. All outputs return to reset values immediately, without waiting for a clk edge. After release, the timer restarts from 0.
